// File: rtl/seg_row_acc_ctrl_if.sv
// Row input and sum output handshakes of the segmented row accumulator.
// The master drives rows and sum_ready; the slave is the accumulator.
interface seg_row_acc_ctrl_if #(
  parameter int SEG_W = 18,
  parameter int ACC_W = 23
);
  logic [SEG_W-1:0] row_in;
  logic             row_valid;
  logic             row_last;
  logic             row_ready;
  logic [ACC_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready;
  logic             err_overrun;

  modport master (
    output row_in, row_valid, row_last, sum_ready,
    input  row_ready, sum, sum_valid, err_overrun
  );

  modport slave (
    input  row_in, row_valid, row_last, sum_ready,
    output row_ready, sum, sum_valid, err_overrun
  );
endinterface

// File: rtl/seg_row_acc_ctrl.sv
// Accumulates a transaction of partial-product rows by sharing one
// five-row reducer across groups of up to five buffered rows.
module seg_red5 #(
  parameter int SEG_W = 18
) (
  input  logic [SEG_W-1:0] i_r0,
  input  logic [SEG_W-1:0] i_r1,
  input  logic [SEG_W-1:0] i_r2,
  input  logic [SEG_W-1:0] i_r3,
  input  logic [SEG_W-1:0] i_r4,
  output logic [SEG_W+2:0] o_sum
);
  assign o_sum = {3'b000, i_r0} + {3'b000, i_r1}
               + {3'b000, i_r2} + {3'b000, i_r3}
               + {3'b000, i_r4};
endmodule

module seg_row_acc_ctrl #(
  parameter int SEG_W    = 18,
  parameter int MAX_ROWS = 20,
  parameter int ACC_W    = 23
) (
  input  logic              clk,
  input  logic              rst,
  seg_row_acc_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_ROWS + 1);
  localparam int RED_W = SEG_W + 3;

  typedef enum logic [1:0] {
    COLLECT,
    REDUCE,
    ACCUM,
    OUT
  } state_t;

  state_t           r_state;
  logic [SEG_W-1:0] r_buf [5];
  logic [2:0]       r_grp;
  logic [CNT_W-1:0] r_tot;
  logic [RED_W-1:0] r_red;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sum;
  logic             r_sum_valid;
  logic             r_err;
  logic             r_close;

  logic             w_ready;
  logic             w_accept;
  logic             w_max;
  logic [RED_W-1:0] w_red;
  logic [ACC_W-1:0] w_acc_nxt;

  assign w_ready   = (r_state == COLLECT) && !rst;
  assign w_accept  = bus.row_valid && w_ready;
  assign w_max     = r_tot == CNT_W'(MAX_ROWS - 1);
  assign w_acc_nxt = r_acc + ACC_W'(r_red);

  seg_red5 #(.SEG_W(SEG_W)) u_red (
    .i_r0  (r_buf[0]),
    .i_r1  (r_buf[1]),
    .i_r2  (r_buf[2]),
    .i_r3  (r_buf[3]),
    .i_r4  (r_buf[4]),
    .o_sum (w_red)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= COLLECT;
      for (int i = 0; i < 5; i++) r_buf[i] <= '0;
      r_grp       <= '0;
      r_tot       <= '0;
      r_red       <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_err       <= 1'b0;
      r_close     <= 1'b0;
    end else begin
      unique case (r_state)
        COLLECT: begin
          if (w_accept) begin
            for (int i = 0; i < 5; i++)
              if (r_grp == 3'(i)) r_buf[i] <= bus.row_in;
            r_grp   <= r_grp + 3'd1;
            r_tot   <= r_tot + CNT_W'(1);
            r_close <= bus.row_last || w_max;
            if (w_max && !bus.row_last) r_err <= 1'b1;
            if (r_grp == 3'd4 || bus.row_last || w_max)
              r_state <= REDUCE;
          end
        end
        REDUCE: begin
          r_red   <= w_red;
          r_state <= ACCUM;
        end
        ACCUM: begin
          r_acc <= w_acc_nxt;
          r_grp <= '0;
          for (int i = 0; i < 5; i++) r_buf[i] <= '0;
          if (r_close) begin
            r_sum       <= w_acc_nxt;
            r_sum_valid <= 1'b1;
            r_state     <= OUT;
          end else begin
            r_state <= COLLECT;
          end
        end
        OUT: begin
          // sum stays latched; only the valid flag drops on handshake
          if (bus.sum_ready) begin
            r_sum_valid <= 1'b0;
            r_acc       <= '0;
            r_tot       <= '0;
            r_close     <= 1'b0;
            r_state     <= COLLECT;
          end
        end
      endcase
    end
  end

  assign bus.row_ready   = w_ready;
  assign bus.sum         = r_sum;
  assign bus.sum_valid   = r_sum_valid;
  assign bus.err_overrun = r_err;
endmodule

// File: tb/tb_seg_row_acc_ctrl.sv
// Directed bench for seg_row_acc_ctrl: hand-computed sums, latency,
// stall pattern, overrun and reset behaviour.
module tb_seg_row_acc_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_tot  = 0;

  seg_row_acc_ctrl_if #(.SEG_W(18), .ACC_W(23)) bus ();

  seg_row_acc_ctrl #(
    .SEG_W(18),
    .MAX_ROWS(20),
    .ACC_W(23)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send(input logic [17:0] v, input logic last,
                      output int waits);
    bus.row_in    = v;
    bus.row_last  = last;
    bus.row_valid = 1'b1;
    waits = 0;
    while (!bus.row_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) chk("send_timeout", 32'(waits), 0);
    @(negedge clk);
  endtask

  task automatic wait_sum(output int lat);
    bus.row_valid = 1'b0;
    bus.row_last  = 1'b0;
    lat = 1;
    while (!bus.sum_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic hs(input string tag);
    bus.sum_ready = 1'b1;
    @(negedge clk);
    bus.sum_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(bus.sum_valid), 0);
    chk({tag, "_hs_ready"}, 32'(bus.row_ready), 1);
  endtask

  initial begin
    int w;
    int lat;
    rst           = 1'b1;
    bus.row_in    = '0;
    bus.row_valid = 1'b0;
    bus.row_last  = 1'b0;
    bus.sum_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.row_ready), 0);
    chk("rst_sum", 32'(bus.sum), 0);
    chk("rst_valid", 32'(bus.sum_valid), 0);
    chk("rst_err", 32'(bus.err_overrun), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.row_ready), 1);

    // five full-scale rows in one group
    for (int i = 1; i <= 5; i++) send(18'h3FFFF, i == 5, w);
    wait_sum(lat);
    chk("full5_lat", 32'(lat), 3);
    chk("full5_sum", 32'(bus.sum), 32'h13FFFB);
    chk("full5_err", 32'(bus.err_overrun), 0);
    hs("full5");

    send(18'd7, 1'b1, w);
    wait_sum(lat);
    chk("one_lat", 32'(lat), 3);
    chk("one_sum", 32'(bus.sum), 7);
    hs("one");

    // rows 1..12: two mid-transaction stalls
    for (int i = 1; i <= 12; i++) begin
      send(18'(i), i == 12, w);
      chk($sformatf("seq_wait%0d", i), 32'(w),
          (i == 6 || i == 11) ? 2 : 0);
    end
    wait_sum(lat);
    chk("seq_lat", 32'(lat), 3);
    chk("seq_sum", 32'(bus.sum), 78);
    hs("seq");

    send(18'd2, 1'b0, w);
    send(18'd3, 1'b1, w);
    wait_sum(lat);
    chk("hold_lat", 32'(lat), 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.sum_valid), 1);
      chk("hold_sum", 32'(bus.sum), 5);
      chk("hold_ready", 32'(bus.row_ready), 0);
    end
    hs("hold");

    // twenty rows, no row_last: overrun
    for (int i = 1; i <= 20; i++) send(18'h3FFFF, 1'b0, w);
    wait_sum(lat);
    chk("ovr_lat", 32'(lat), 3);
    chk("ovr_sum", 32'(bus.sum), 5242860);
    chk("ovr_err", 32'(bus.err_overrun), 1);
    hs("ovr");
    chk("ovr_err_sticky", 32'(bus.err_overrun), 1);
    send(18'd4, 1'b1, w);
    wait_sum(lat);
    chk("after_ovr_sum", 32'(bus.sum), 4);
    chk("after_ovr_err", 32'(bus.err_overrun), 1);
    hs("after_ovr");

    // reset during REDUCE of a 3-row group
    send(18'd1, 1'b0, w);
    send(18'd2, 1'b0, w);
    send(18'd4, 1'b1, w);
    bus.row_valid = 1'b0;
    bus.row_last  = 1'b0;
    rst = 1'b1;
    chk("mid_rst_ready0", 32'(bus.row_ready), 0);
    @(negedge clk);
    chk("mid_rst_ready1", 32'(bus.row_ready), 0);
    chk("mid_rst_sum", 32'(bus.sum), 0);
    chk("mid_rst_valid", 32'(bus.sum_valid), 0);
    chk("mid_rst_err", 32'(bus.err_overrun), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready2", 32'(bus.row_ready), 1);
    chk("mid_rst_valid2", 32'(bus.sum_valid), 0);
    send(18'd3, 1'b0, w);
    send(18'd4, 1'b1, w);
    wait_sum(lat);
    chk("mid_rst_lat", 32'(lat), 3);
    chk("mid_rst_new_sum", 32'(bus.sum), 7);
    hs("mid_rst");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seg_row_acc_ctrl.md
SEG_ROW_ACC_CTRL -- requirements
Module: seg_row_acc_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- SEG_W, 18: row width (`DATA_WIDTH/`KO_PARAMETER).
- MAX_ROWS, 20: maximum rows per transaction.
- ACC_W, 23: accumulator/sum width; must satisfy MAX_ROWS*(2^SEG_W-1) < 2^ACC_W.
REQ-002 Ports SHALL be, one per line:
- clk  in  1: single clock; all state updates on rising edge.
- rst  in  1: reset, synchronous, active-high.
- row_in  in  SEG_W: partial-product row.
- row_valid  in  1: row_in valid.
- row_last  in  1: row is the last of the transaction.
- row_ready  out  1: block accepts a row.
- sum  out  ACC_W: transaction sum.
- sum_valid  out  1: sum valid.
- sum_ready  in  1: consumer accepts sum.
- err_overrun  out  1: sticky; MAX_ROWS reached without row_last.
REQ-003 The block SHALL have exactly one clock domain (clk) and one reset (rst), synchronous and active-high.

Function
REQ-004 The block SHALL instantiate one 5-row segment reducer (five SEG_W-bit rows in, SEG_W+3-bit sum out) and time-share it across groups of up to 5 rows.
REQ-005 The FSM SHALL have states COLLECT, REDUCE, ACCUM, OUT; reset state COLLECT.
REQ-006 row_ready SHALL be 1 only in COLLECT; a row is accepted when row_valid && row_ready.
REQ-007 In COLLECT, an accepted row SHALL be written to buffer slot grp_cnt (0..4); grp_cnt and total row count tot_cnt each increment by 1.
REQ-008 COLLECT->REDUCE SHALL occur on the cycle a row is accepted with grp_cnt==4, row_last==1, or tot_cnt==MAX_ROWS-1.
REQ-009 In REDUCE (1 cycle), unfilled buffer slots SHALL drive zero into the reducer; reducer output SHALL be registered into red_q (SEG_W+3 bits).
REQ-010 In ACCUM (1 cycle), acc SHALL take acc + zero-extended red_q; grp_cnt and all buffer slots clear to 0.
REQ-011 ACCUM->OUT SHALL occur if the group was closed by row_last or by MAX_ROWS; otherwise ACCUM->COLLECT.
REQ-012 In OUT, sum_valid SHALL be 1 and sum SHALL equal acc, both held stable until sum_ready==1.
REQ-013 On sum_valid && sum_ready, the FSM SHALL go to COLLECT next cycle, with acc and tot_cnt cleared to 0.
REQ-014 Latency: a row accepted with row_last in cycle T SHALL yield sum_valid=1 in cycle T+3.
REQ-015 Mid-transaction groups SHALL stall input 2 cycles: row_ready=0 in the REDUCE and ACCUM cycles.
REQ-016 If the MAX_ROWS-th row is accepted with row_last==0, the block SHALL treat it as last and set err_overrun=1; err_overrun stays 1 until reset.
REQ-017 Arithmetic SHALL be unsigned, and acc SHALL never wrap for legal parameters (REQ-001).
REQ-018 row_last on the 5th row of a group SHALL close both the group and the transaction, producing a single REDUCE/ACCUM pass.

Reset
REQ-019 While rst==1 at a clock edge, the block SHALL set: state=COLLECT; buffer, grp_cnt, tot_cnt, red_q and acc to 0; sum_valid=0, sum=0, err_overrun=0.
REQ-020 rst asserted in any state, including mid-transaction, SHALL discard partial data; the first row after rst deasserts starts a new transaction.
REQ-021 row_ready SHALL be 0 during a cycle in which rst==1.

Verification
REQ-022 Five rows of 0x3FFFF, row_last on the 5th: sum=0x13FFFB (1310715), sum_valid 3 cycles after the last accept, err_overrun=0.
REQ-023 One row of 7 with row_last: sum=7, with the four zero-padded slots contributing nothing.
REQ-024 Rows 1..12 sent back-to-back, row_last on row 12: sum=78; row_ready=0 for exactly 2 cycles after rows 5 and 10.
REQ-025 Twenty rows of 0x3FFFF, no row_last: sum=5242860 and err_overrun=1, which persists after the sum handshake until rst.
REQ-026 sum_ready held 0 for 4 cycles in OUT: sum and sum_valid stable and row_ready=0 throughout; sum_ready=1 returns the FSM to COLLECT next cycle.
REQ-027 rst pulsed during REDUCE of a 3-row group, then rows 3 and 4 with row_last: all outputs 0 after reset, then sum=7.
